// File: rtl/mem_wb_pkg.sv
// Shared types and encodings for the memory/writeback stage.
//   - writeback select codes, load/store funct3 codes
//   - FSM state enum and the WB pipeline register payload
package mem_wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned RD_W   = 5;

    // Writeback source select
    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // WB pipeline register contents (register-file write port)
    typedef struct packed {
        logic              regwrite;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] result;
    } wb_t;

endpackage

// File: rtl/mem_wb_stage_lsu_align.sv
// lsu_align: combinational store lane/byte-enable generation and load
// extraction with sign/zero extension.
//   funct3      : access width code
//   addr_lo     : low two address bits (lane select)
//   is_store    : 1 = store, 0 = load (loads use all four byte enables)
//   store_data  : unaligned store data from the register file
//   load_word   : raw word returned by data memory
//   be_c        : byte enables
//   wdata_c     : lane-replicated store data
//   load_data_c : aligned, extended load result
module lsu_align
    import mem_wb_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic              is_store,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] load_word,
    output logic [BE_W-1:0]   be_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] load_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: replicate data across lanes so memory only needs the byte enables
    always_comb begin : store_lanes
        be_c    = '1;
        wdata_c = store_data;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    be_c    = BE_W'(4'b0001 << addr_lo);
                    wdata_c = {4{store_data[7:0]}};
                end
                F3_H: begin
                    be_c    = BE_W'(4'b0011 << {addr_lo[1], 1'b0});
                    wdata_c = {2{store_data[15:0]}};
                end
                F3_W:    ;
                default: ;
            endcase
        end
    end

    // Load side: pick the addressed lane, then extend
    always_comb begin : load_extract
        byte_sel    = load_word[7:0];
        half_sel    = addr_lo[1] ? load_word[31:16] : load_word[15:0];
        load_data_c = load_word;
        case (addr_lo)
            2'd0:    byte_sel = load_word[7:0];
            2'd1:    byte_sel = load_word[15:8];
            2'd2:    byte_sel = load_word[23:16];
            default: byte_sel = load_word[31:24];
        endcase
        case (funct3)
            F3_B:    load_data_c = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_c = {24'd0, byte_sel};
            F3_H:    load_data_c = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_c = {16'd0, half_sel};
            default: load_data_c = load_word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and writeback stage. Runs loads/stores over a
// ready/valid data-memory handshake, stalls upstream while an access is in
// flight, and registers the selected writeback result.
//   inputs  : M-stage instruction fields (validM, regwriteM, memrwM, wbselM,
//             funct3M, rdM, alu_resultM, rd2M, pc4M), dmem_ready/rvalid/rdata
//   outputs : stallM, dmem_req/we/addr/be/wdata, regwriteW/rdW/resultW
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validM,
    input  logic              regwriteM,
    input  logic              memrwM,
    input  logic [1:0]        wbselM,
    input  logic [2:0]        funct3M,
    input  logic [4:0]        rdM,
    input  logic [XLEN-1:0]   alu_resultM,
    input  logic [XLEN-1:0]   rd2M,
    input  logic [XLEN-1:0]   pc4M,
    output logic              stallM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ready,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              regwriteW,
    output logic [4:0]        rdW,
    output logic [XLEN-1:0]   resultW
);

    logic            is_load;
    logic            is_store;
    logic            is_memop;
    state_e          state_q, state_d;
    logic            dmem_req_q, dmem_req_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic [XLEN-1:0] ext_data;
    logic [XLEN-1:0] wb_result;
    wb_t             wb_q, wb_d;

    assign is_load  = validM & regwriteM & (wbselM == WB_MEM) & ~memrwM;
    assign is_store = validM & memrwM;
    assign is_memop = is_load | is_store;

    lsu_align u_lsu_align (
        .funct3      (funct3M),
        .addr_lo     (alu_resultM[1:0]),
        .is_store    (is_store),
        .store_data  (rd2M),
        .load_word   (dmem_rdata),
        .be_c        (dmem_be),
        .wdata_c     (dmem_wdata),
        .load_data_c (ext_data)
    );

    // Access FSM; rvalid is only honoured in RESP so early responses are dropped
    always_comb begin : fsm_next
        state_d     = state_q;
        load_data_d = load_data_q;
        case (state_q)
            ST_IDLE: if (is_memop) state_d = ST_REQ;
            ST_REQ:  if (dmem_ready) state_d = is_store ? ST_DONE : ST_RESP;
            ST_RESP: begin
                if (dmem_rvalid) begin
                    load_data_d = ext_data;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        dmem_req_d = (state_d == ST_REQ);
    end

    // Writeback mux and WB register next value; a stall inserts a bubble
    always_comb begin : wb_next
        wb_result = alu_resultM;
        case (wbselM)
            WB_MEM:  wb_result = load_data_q;
            WB_PC4:  wb_result = pc4M;
            WB_ALU:  wb_result = alu_resultM;
            default: wb_result = alu_resultM;
        endcase
        wb_d          = wb_q;
        wb_d.regwrite = 1'b0;
        if (!stallM) begin
            wb_d.regwrite = validM & regwriteM & (rdM != 5'd0);
            wb_d.rd       = rdM;
            wb_d.result   = wb_result;
        end
    end

    always_ff @(posedge clk) begin : seq
        if (rst) begin
            state_q     <= ST_IDLE;
            dmem_req_q  <= 1'b0;
            load_data_q <= '0;
            wb_q        <= '0;
        end else begin
            state_q     <= state_d;
            dmem_req_q  <= dmem_req_d;
            load_data_q <= load_data_d;
            wb_q        <= wb_d;
        end
    end

    // Stall drops in DONE so the finished instruction retires that cycle
    assign stallM     = is_memop & (state_q != ST_DONE);
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = is_store;
    assign dmem_addr  = {alu_resultM[XLEN-1:2], 2'b00};
    assign regwriteW  = wb_q.regwrite;
    assign rdW        = wb_q.rd;
    assign resultW    = wb_q.result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed cases plus random instruction
// stream with a behavioural memory responder.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        validM, regwriteM, memrwM;
    logic [1:0]  wbselM;
    logic [2:0]  funct3M;
    logic [4:0]  rdM;
    logic [31:0] alu_resultM, rd2M, pc4M;
    logic        stallM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        regwriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .validM(validM), .regwriteM(regwriteM), .memrwM(memrwM),
        .wbselM(wbselM), .funct3M(funct3M), .rdM(rdM),
        .alu_resultM(alu_resultM), .rd2M(rd2M), .pc4M(pc4M),
        .stallM(stallM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        chk_res;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_load = 32'd0;
    logic        load_known = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: load result from raw word using shifts and arithmetic extension
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(a))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] a,
                                          input logic st);
        if (!st) return 4'hF;
        case (f3)
            3'b000:  return 4'(1 << int'(a));
            3'b001:  return (a >= 2'd2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return (d & 32'hFF) * 32'h0101_0101;
            3'b001:  return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // Issue one instruction at a negedge; acts as memory with n ready-wait and
    // m rvalid-wait cycles; returns at the negedge after it retires.
    task automatic run_instr(input logic v, input logic rw, input logic mrw,
                             input logic [1:0] wb, input logic [2:0] f3, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] d2, input logic [31:0] p4,
                             input int n, input int m, input logic [31:0] rdat);
        logic        is_ld, is_st, memop, exp_req;
        logic [31:0] ldv;
        exp_t        e;
        int          exp_stall, stall_cnt, cyc;
        is_ld     = v & rw & (wb == 2'b00) & !mrw;
        is_st     = v & mrw;
        memop     = is_ld | is_st;
        exp_stall = is_ld ? 3 + n + m : (is_st ? 2 + n : 0);
        ldv       = ref_load(f3, alu[1:0], rdat);
        e.rw      = v & rw & (rd != 5'd0);
        e.rd      = rd;
        case (wb)
            2'b00: begin e.res = is_ld ? ldv : last_load; e.chk_res = is_ld | load_known; end
            2'b10: begin e.res = p4;  e.chk_res = 1'b1; end
            default: begin e.res = alu; e.chk_res = 1'b1; end
        endcase
        if (is_ld) begin last_load = ldv; load_known = 1'b1; end
        validM = v; regwriteM = rw; memrwM = mrw; wbselM = wb; funct3M = f3;
        rdM = rd; alu_resultM = alu; rd2M = d2; pc4M = p4;
        exp_q.push_back(e);
        stall_cnt = 0;
        #1;
        for (cyc = 0; cyc < 64; cyc++) begin
            exp_req = memop && (cyc >= 1) && (cyc <= n + 1);
            chk("dmem_req", 32'(dmem_req), 32'(exp_req));
            if (exp_req) begin
                chk("dmem_we", 32'(dmem_we), 32'(is_st));
                chk("dmem_addr", dmem_addr, alu & 32'hFFFF_FFFC);
                chk("dmem_be", 32'(dmem_be), 32'(ref_be(f3, alu[1:0], is_st)));
                if (is_st) chk("dmem_wdata", dmem_wdata, ref_wdata(f3, d2));
                dmem_ready  = (cyc == n + 1);
                dmem_rvalid = 1'($urandom);
                dmem_rdata  = $urandom;
            end else begin
                dmem_ready = 1'b0;
                if (is_ld && (cyc == n + 2 + m)) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdat;
                end else begin
                    dmem_rvalid = 1'b0;
                    dmem_rdata  = $urandom;
                end
            end
            if (!stallM) break;
            stall_cnt++;
            @(negedge clk);
            #1;
        end
        if (cyc == 64) begin
            checks++; errors++;
            $display("FAIL stall_timeout: stallM still high after 64 cycles at %0t", $time);
        end
        chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        @(negedge clk);
    endtask

    // Monitor: every non-stalled cycle retires one scoreboard entry
    initial begin : monitor
        exp_t e, last;
        logic s, r;
        last = '{rw: 1'b0, rd: 5'd0, res: 32'd0, chk_res: 1'b1};
        forever begin
            @(negedge clk);
            #2;
            s = stallM;
            r = rst;
            @(posedge clk);
            #1;
            if (r) begin
                exp_q.delete();
                last = '{rw: 1'b0, rd: 5'd0, res: 32'd0, chk_res: 1'b1};
            end else if (s) begin
                chk("bubble_regwriteW", 32'(regwriteW), 32'd0);
                chk("hold_rdW", 32'(rdW), 32'(last.rd));
                if (last.chk_res) chk("hold_resultW", resultW, last.res);
            end else if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty: WB retired with no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("regwriteW", 32'(regwriteW), 32'(e.rw));
                chk("rdW", 32'(rdW), 32'(e.rd));
                if (e.chk_res) chk("resultW", resultW, e.res);
                last = e;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int          cls;
        logic        v, rw, mrw;
        logic [1:0]  wb;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu, d2, p4, rdat;
        int          n, m;

        rst = 1'b1;
        validM = 1'b0; regwriteM = 1'b0; memrwM = 1'b0; wbselM = 2'b00; funct3M = 3'b000;
        rdM = 5'd0; alu_resultM = 32'd0; rd2M = 32'd0; pc4M = 32'd0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_regwriteW", 32'(regwriteW), 32'd0);
        chk("reset_rdW", 32'(rdW), 32'd0);
        chk("reset_resultW", resultW, 32'd0);
        chk("reset_dmem_req", 32'(dmem_req), 32'd0);
        chk("reset_stallM", 32'(stallM), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_instr(1, 1, 0, 2'b01, 3'b000, 5'd5, 32'h1234, 32'd0, 32'h8, 0, 0, 32'd0);          // add
        run_instr(1, 0, 1, 2'b01, 3'b010, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'hC, 0, 0, 32'd0);   // sw
        run_instr(1, 1, 0, 2'b00, 3'b000, 5'd7, 32'h103, 32'd0, 32'h10, 2, 2, 32'h80FF_FF7F); // lb
        run_instr(1, 1, 0, 2'b00, 3'b100, 5'd8, 32'h103, 32'd0, 32'h14, 2, 2, 32'h80FF_FF7F); // lbu
        run_instr(1, 0, 1, 2'b01, 3'b001, 5'd0, 32'h102, 32'h0000_ABCD, 32'h18, 1, 0, 32'd0); // sh
        run_instr(1, 1, 0, 2'b10, 3'b000, 5'd1, 32'h999, 32'd0, 32'h44, 0, 0, 32'd0);          // jal
        run_instr(1, 1, 0, 2'b10, 3'b000, 5'd0, 32'h999, 32'd0, 32'h44, 0, 0, 32'd0);          // jal x0
        run_instr(1, 1, 0, 2'b00, 3'b001, 5'd0, 32'h202, 32'd0, 32'h48, 1, 1, 32'h8001_7FFF); // lh x0
        run_instr(0, 1, 1, 2'b00, 3'b010, 5'd9, 32'h300, 32'h55, 32'h4C, 0, 0, 32'd0);         // bubble
        run_instr(1, 1, 0, 2'b00, 3'b101, 5'd10, 32'h402, 32'd0, 32'h50, 0, 3, 32'h9ABC_1234);// lhu

        // Random stream
        for (int i = 0; i < 300; i++) begin
            cls  = $urandom_range(0, 5);
            f3   = 3'($urandom);
            rd   = 5'($urandom);
            alu  = $urandom;
            d2   = $urandom;
            p4   = $urandom & 32'hFFFF_FFFC;
            rdat = $urandom;
            wb   = 2'($urandom);
            n    = $urandom_range(0, 3);
            m    = $urandom_range(0, 3);
            v = 1'b1; rw = 1'b1; mrw = 1'b0;
            case (cls)
                0: wb = {wb[1], 1'b1};
                1: begin rw = 1'b0; mrw = 1'b1; end
                2: wb = 2'b00;
                3: wb = 2'b10;
                4: begin v = 1'b0; rw = 1'($urandom); mrw = 1'($urandom); end
                default: rw = 1'b0;
            endcase
            run_instr(v, rw, mrw, wb, f3, rd, alu, d2, p4, n, m, rdat);
        end

        // Reset while a load waits in RESP
        validM = 1'b1; regwriteM = 1'b1; memrwM = 1'b0; wbselM = 2'b00; funct3M = 3'b010;
        rdM = 5'd3; alu_resultM = 32'h200; rd2M = 32'd0; pc4M = 32'h60;
        #1;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        @(negedge clk); #1;
        chk("rst_test_req", 32'(dmem_req), 32'd1);
        dmem_ready = 1'b1;
        @(negedge clk); #1;
        dmem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_resp_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_resp_regwriteW", 32'(regwriteW), 32'd0);
        chk("rst_resp_rdW", 32'(rdW), 32'd0);
        chk("rst_resp_resultW", resultW, 32'd0);
        rst = 1'b0;
        validM = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        load_known = 1'b0;
        exp_q.push_back('{rw: 1'b0, rd: 5'd3, res: 32'd0, chk_res: 1'b0});
        @(negedge clk);
        chk("late_rvalid_req", 32'(dmem_req), 32'd0);
        dmem_rvalid = 1'b0;
        run_instr(1, 1, 0, 2'b00, 3'b000, 5'd4, 32'h201, 32'd0, 32'h64, 0, 0, 32'h0000_7F00);
        run_instr(1, 1, 0, 2'b01, 3'b000, 5'd6, 32'hCAFE, 32'd0, 32'h68, 0, 0, 32'd0);
        run_instr(1, 0, 1, 2'b01, 3'b000, 5'd0, 32'h301, 32'h0000_00A5, 32'h6C, 2, 0, 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
